// File: rtl/sar_search8_pkg.sv
// sar_search8_pkg: compare codes and state encoding shared by the SAR search controller,
// the magnitude comparator and their benches.
package sar_search8_pkg;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;
    typedef enum logic {IDLE, PROBE} state_t;
endpackage

// File: rtl/sar_search8.sv
// sar_search8: MSB-first successive-approximation search driving an external comparator's probe.
// Define SAR_SEARCH8_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search8
    import sar_search8_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_DLY = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [2:0]       iCmp,
    output logic [WIDTH-1:0] oProbe,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic             oErr
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state_q;
    logic [WIDTH-1:0] probe_q, result_q, bit_d, val_d;
    logic [IW-1:0]    idx_q;
    logic [3:0]       hold_q;
    logic             busy_q, done_q, err_q, sample_d, illegal_d, last_d;
    always_comb begin
        bit_d     = WIDTH'(1) << idx_q;
        sample_d  = (state_q == PROBE) && (hold_q == 4'(SAMPLE_DLY - 1));
        illegal_d = !(iCmp == CMP_GT || iCmp == CMP_EQ || iCmp == CMP_LT);
        val_d     = (iCmp == CMP_GT) ? (probe_q & ~bit_d) : probe_q;
`ifdef SAR_SEARCH8_EARLY_EXIT_EN
        last_d    = (idx_q == '0) || (iCmp == CMP_EQ);
`else
        last_d    = (idx_q == '0);
`endif
    end
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            probe_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                // the oDone cycle still belongs to the finishing search, so a start there is dropped
                if (iStart && !done_q) begin
                    state_q  <= PROBE;
                    busy_q   <= 1'b1;
                    probe_q  <= {1'b1, {(WIDTH-1){1'b0}}};
                    idx_q    <= IW'(WIDTH - 1);
                    hold_q   <= '0;
                    result_q <= '0;
                    err_q    <= 1'b0;
                end
            end else if (!sample_d) begin
                hold_q <= hold_q + 4'd1;
            end else if (illegal_d || last_d) begin
                result_q <= illegal_d ? '0 : val_d;
                err_q    <= illegal_d;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                probe_q  <= '0;
                idx_q    <= '0;
                hold_q   <= '0;
                state_q  <= IDLE;
            end else begin
                probe_q <= val_d | (bit_d >> 1);
                idx_q   <= idx_q - 1'b1;
                hold_q  <= '0;
            end
        end
    end
    assign oProbe  = probe_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = result_q;
    assign oErr    = err_q;
endmodule
